// File: rtl/rv_mem_pkg.sv
// Shared types and default widths for the unified-memory port arbiter.
package rv_mem_pkg;

   localparam int unsigned ADDR_W_DEF     = 32;
   localparam int unsigned DATA_W_DEF     = 32;
   localparam int unsigned BE_W_DEF       = DATA_W_DEF / 8;
   localparam int unsigned STARVE_MAX_DEF = 4;

   localparam logic [BE_W_DEF-1:0] BE_ALL = '1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } arb_state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_LS   = 2'd2
   } owner_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of LS grants taken while IF was waiting.
module arb_starve_ctr #(
   parameter int unsigned MAX = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic clr,
   output logic at_max
);

   localparam int unsigned CW = (MAX < 1) ? 1 : $clog2(MAX + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q < CW'(MAX))) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign at_max = (cnt_q >= CW'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store onto one single-ported memory, one
// transaction in flight, routing each response back to its owner.
module mem_port_arbiter
   import rv_mem_pkg::*;
#(
   parameter int unsigned ADDR_W     = ADDR_W_DEF,
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_gnt,
   output logic                if_rvalid,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                ls_req,
   input  logic                ls_we,
   input  logic [DATA_W/8-1:0] ls_be,
   input  logic [ADDR_W-1:0]   ls_addr,
   input  logic [DATA_W-1:0]   ls_wdata,
   output logic                ls_gnt,
   output logic                ls_rvalid,
   output logic [DATA_W-1:0]   ls_rdata,
   output logic                mem_req,
   output logic                mem_we,
   output logic [DATA_W/8-1:0] mem_be,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic                mem_gnt,
   input  logic                mem_rvalid,
   input  logic [DATA_W-1:0]   mem_rdata
);

   localparam int unsigned BE_W = DATA_W / 8;

   arb_state_t        state_q, state_d;
   owner_t            owner_q, owner_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [BE_W-1:0]   mem_be_q, mem_be_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

   logic starve_at_max;
   logic ls_win;
   logic if_win;

   // LS has priority unless IF has been passed over STARVE_MAX times.
   assign ls_win = ls_req && (!if_req || !starve_at_max);
   assign if_win = if_req && !ls_win;

   arb_starve_ctr #(
      .MAX (STARVE_MAX)
   ) u_starve (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc    (ls_gnt && if_req),
      .clr    (if_gnt),
      .at_max (starve_at_max)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (ls_req || if_req) state_d = ST_ISSUE;
         ST_ISSUE: if (mem_gnt)          state_d = ST_RESP;
         ST_RESP:  if (mem_rvalid)       state_d = ST_IDLE;
         default:                        state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      if_gnt      = 1'b0;
      ls_gnt      = 1'b0;
      if_rvalid   = 1'b0;
      ls_rvalid   = 1'b0;
      owner_d     = owner_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_be_d    = mem_be_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      unique case (state_q)
         ST_IDLE: begin
            if (ls_win) begin
               ls_gnt      = 1'b1;
               owner_d     = OWN_LS;
               mem_req_d   = 1'b1;
               mem_we_d    = ls_we;
               mem_be_d    = ls_be;
               mem_addr_d  = ls_addr;
               mem_wdata_d = ls_wdata;
            end else if (if_win) begin
               if_gnt      = 1'b1;
               owner_d     = OWN_IF;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_be_d    = '1;
               mem_addr_d  = if_addr;
            end
         end
         ST_ISSUE: begin
            if (mem_gnt) mem_req_d = 1'b0;
         end
         ST_RESP: begin
            if (mem_rvalid) begin
               if_rvalid = (owner_q == OWN_IF);
               ls_rvalid = (owner_q == OWN_LS);
               owner_d   = OWN_NONE;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_q     <= OWN_NONE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         owner_q     <= owner_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_be_q    <= mem_be_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_be    = mem_be_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign if_rdata  = mem_rdata;
   assign ls_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change #1 after posedge,
// outputs are sampled on the falling edge.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt, if_rvalid;
   logic [31:0] if_rdata;
   logic        ls_req, ls_we;
   logic [3:0]  ls_be;
   logic [31:0] ls_addr, ls_wdata;
   logic        ls_gnt, ls_rvalid;
   logic [31:0] ls_rdata;
   logic        mem_req, mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_gnt, mem_rvalid;
   logic [31:0] mem_rdata;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   mem_port_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .if_req     (if_req),
      .if_addr    (if_addr),
      .if_gnt     (if_gnt),
      .if_rvalid  (if_rvalid),
      .if_rdata   (if_rdata),
      .ls_req     (ls_req),
      .ls_we      (ls_we),
      .ls_be      (ls_be),
      .ls_addr    (ls_addr),
      .ls_wdata   (ls_wdata),
      .ls_gnt     (ls_gnt),
      .ls_rvalid  (ls_rvalid),
      .ls_rdata   (ls_rdata),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_be     (mem_be),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   // Expected grant winners for the starvation run (1 = LS, 0 = IF).
   localparam logic [9:0] STARVE_ORDER = 10'b1111_0_1111_0;

   initial begin
      logic exp_ls;
      int   seen;
      rst_n = 1'b0;
      if_req = 0; if_addr = '0;
      ls_req = 0; ls_we = 0; ls_be = '0; ls_addr = '0; ls_wdata = '0;
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;

      settle();
      chk("rst_mem_req", 32'(mem_req), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_be", 32'(mem_be), 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_gnts", {30'd0, if_gnt, ls_gnt}, 0);
      tick();
      rst_n = 1'b1;
      tick();

      // Lone fetch
      if_req = 1; if_addr = 32'h10;
      settle();
      chk("f_if_gnt", 32'(if_gnt), 1);
      chk("f_ls_gnt", 32'(ls_gnt), 0);
      chk("f_mem_req_c0", 32'(mem_req), 0);
      tick();
      if_req = 0; mem_gnt = 1;
      settle();
      chk("f_mem_req", 32'(mem_req), 1);
      chk("f_mem_addr", mem_addr, 32'h10);
      chk("f_mem_we", 32'(mem_we), 0);
      chk("f_mem_be", 32'(mem_be), 32'hF);
      tick();
      mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0020_C1B3;
      settle();
      chk("f_if_rvalid", 32'(if_rvalid), 1);
      chk("f_if_rdata", if_rdata, 32'h0020_C1B3);
      chk("f_ls_rvalid", 32'(ls_rvalid), 0);
      chk("f_mem_req_resp", 32'(mem_req), 0);
      tick();
      mem_rvalid = 0;
      settle();
      chk("f_if_rvalid_end", 32'(if_rvalid), 0);
      tick();

      // Store with three stalled mem_gnt cycles
      ls_req = 1; ls_we = 1; ls_be = 4'h3; ls_addr = 32'h100; ls_wdata = 32'hDEAD_BEEF;
      settle();
      chk("s_ls_gnt", 32'(ls_gnt), 1);
      chk("s_if_gnt", 32'(if_gnt), 0);
      tick();
      ls_req = 0; ls_we = 0; ls_be = '0; ls_addr = '0; ls_wdata = '0;
      for (int k = 0; k < 4; k++) begin
         mem_gnt = (k == 3);
         settle();
         chk("s_mem_req", 32'(mem_req), 1);
         chk("s_mem_addr", mem_addr, 32'h100);
         chk("s_mem_we", 32'(mem_we), 1);
         chk("s_mem_be", 32'(mem_be), 32'h3);
         chk("s_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
         chk("s_no_gnt_issue", {30'd0, if_gnt, ls_gnt}, 0);
         tick();
      end
      mem_gnt = 0; ls_req = 1; ls_addr = 32'h104;
      settle();
      chk("s_wait_rvalid", 32'(ls_rvalid), 0);
      chk("s_no_gnt_resp", 32'(ls_gnt), 0);
      chk("s_mem_req_drop", 32'(mem_req), 0);
      tick();
      ls_req = 0; ls_addr = '0;
      mem_rvalid = 1;
      settle();
      chk("s_ls_rvalid", 32'(ls_rvalid), 1);
      chk("s_if_rvalid", 32'(if_rvalid), 0);
      tick();
      mem_rvalid = 0;
      settle();
      chk("s_ls_rvalid_end", 32'(ls_rvalid), 0);
      tick();

      // Stray response while idle
      mem_rvalid = 1; mem_rdata = 32'hFFFF_FFFF;
      settle();
      chk("x_if_rvalid", 32'(if_rvalid), 0);
      chk("x_ls_rvalid", 32'(ls_rvalid), 0);
      tick();
      mem_rvalid = 0;
      settle();
      chk("x_still_idle", 32'(mem_req), 0);
      tick();

      // Starvation: both requesters held, memory answers immediately
      if_req = 1; if_addr = 32'h40; ls_req = 1; ls_addr = 32'h300; ls_be = 4'hF;
      mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'h5555_AAAA;
      for (int g = 0; g < 10; g++) begin
         seen = 0;
         for (int w = 0; w < 6 && seen == 0; w++) begin
            settle();
            if (if_gnt || ls_gnt) seen = w + 1;
            else tick();
         end
         chk("starve_gnt_seen", 32'(seen != 0), 1);
         if (seen == 0) break;
         exp_ls = STARVE_ORDER[9-g];
         chk("starve_order_ls", 32'(ls_gnt), 32'(exp_ls));
         chk("starve_order_if", 32'(if_gnt), 32'(!exp_ls));
         if (g > 0) chk("starve_spacing", 32'(seen), 3);
         tick();
      end
      if_req = 0; ls_req = 0;
      tick();
      tick();
      mem_gnt = 0; mem_rvalid = 0;
      tick();

      // Reset while a load sits in RESP
      ls_req = 1; ls_we = 0; ls_addr = 32'h200;
      settle();
      chk("r_ls_gnt", 32'(ls_gnt), 1);
      tick();
      ls_req = 0; mem_gnt = 1;
      settle();
      chk("r_mem_addr", mem_addr, 32'h200);
      tick();
      mem_gnt = 0;
      settle();
      chk("r_in_resp", 32'(ls_rvalid), 0);
      #1 rst_n = 1'b0;
      #1;
      chk("r_mem_req", 32'(mem_req), 0);
      chk("r_mem_addr0", mem_addr, 0);
      chk("r_mem_be0", 32'(mem_be), 0);
      tick();
      rst_n = 1'b1;
      mem_rvalid = 1; mem_rdata = 32'hCAFE_0001;
      ls_req = 1; ls_addr = 32'h204;
      settle();
      chk("r_no_ls_rvalid", 32'(ls_rvalid), 0);
      chk("r_no_if_rvalid", 32'(if_rvalid), 0);
      chk("r_idle_gnt", 32'(ls_gnt), 1);
      tick();
      ls_req = 0; mem_rvalid = 0; mem_gnt = 1;
      settle();
      chk("r2_mem_addr", mem_addr, 32'h204);
      chk("r2_mem_req", 32'(mem_req), 1);
      tick();
      mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h1234_5678;
      settle();
      chk("r2_ls_rvalid", 32'(ls_rvalid), 1);
      chk("r2_ls_rdata", ls_rdata, 32'h1234_5678);
      tick();
      mem_rvalid = 0;
      tick();

      // Back-to-back fetches with an always-ready memory
      if_req = 1; if_addr = 32'h80; mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'h0000_0013;
      for (int c = 0; c < 9; c++) begin
         settle();
         chk("b2b_if_gnt", 32'(if_gnt), 32'((c % 3) == 0));
         chk("b2b_ls_gnt", 32'(ls_gnt), 0);
         chk("b2b_if_rvalid", 32'(if_rvalid), 32'((c % 3) == 2));
         tick();
      end
      if_req = 0; mem_gnt = 0; mem_rvalid = 0;
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
